// File: rtl/hub75_init_inject_multi_if.sv
// ============================================================================
//  Module   : hub75_init_inject_multi_if
//  Purpose  : Bundles the PHY bus (scan/shifter/BCM side in, hub75_phy side
//             out), the scan go/ready handshake, and the re-init/busy pair
//             seen by hub75_init_inject_multi.
//  Modports : slave  - the injector (consumes phy_in_*, drives phy_out_*)
//             master - the surrounding pipeline / testbench
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hub75_init_inject_multi_if #(
  parameter int N_BANKS = 2,
  parameter int N_CHANS = 3,
  parameter int N_ROWS  = 32
);
  localparam int c_LOG_N_ROWS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int c_LANES      = N_BANKS * N_CHANS;

  // PHY bus from the scan / shifter / BCM pipeline
  logic                    phy_in_addr_inc;
  logic                    phy_in_addr_rst;
  logic [c_LOG_N_ROWS-1:0] phy_in_addr;
  logic [c_LANES-1:0]      phy_in_data;
  logic                    phy_in_clk;
  logic                    phy_in_le;
  logic                    phy_in_blank;

  // PHY bus towards hub75_phy
  logic                    phy_out_addr_inc;
  logic                    phy_out_addr_rst;
  logic [c_LOG_N_ROWS-1:0] phy_out_addr;
  logic [c_LANES-1:0]      phy_out_data;
  logic                    phy_out_clk;
  logic                    phy_out_le;
  logic                    phy_out_blank;

  // Scan handshake, idle status and re-init control
  logic                    scan_go_in;
  logic                    scan_go_out;
  logic                    scan_rdy_in;
  logic                    scan_rdy_out;
  logic                    bcm_rdy_in;
  logic                    reinit;
  logic                    busy;

  modport slave (
    input  phy_in_addr_inc, phy_in_addr_rst, phy_in_addr, phy_in_data,
           phy_in_clk, phy_in_le, phy_in_blank,
    output phy_out_addr_inc, phy_out_addr_rst, phy_out_addr, phy_out_data,
           phy_out_clk, phy_out_le, phy_out_blank,
    input  scan_go_in, scan_rdy_in, bcm_rdy_in, reinit,
    output scan_go_out, scan_rdy_out, busy
  );

  modport master (
    output phy_in_addr_inc, phy_in_addr_rst, phy_in_addr, phy_in_data,
           phy_in_clk, phy_in_le, phy_in_blank,
    input  phy_out_addr_inc, phy_out_addr_rst, phy_out_addr, phy_out_data,
           phy_out_clk, phy_out_le, phy_out_blank,
    output scan_go_in, scan_rdy_in, bcm_rdy_in, reinit,
    input  scan_go_out, scan_rdy_out, busy
  );
endinterface

`default_nettype wire

// File: rtl/hub75_init_inject_multi.sv
// ============================================================================
//  Module   : hub75_init_inject_multi
//  Purpose  : Sits between the scan/BCM pipeline and hub75_phy. After reset
//             and on every re-init request it takes over the PHY bus and
//             shifts a table of N_REGS driver-IC control words (FM6126 style,
//             LE held for the last REG_LE[i] clocks) into every bank/channel
//             lane. Otherwise it passes the PHY bus through (one register
//             stage) and the scan handshake through (combinational).
//  Ports    : clk  - system clock
//             rst  - synchronous reset, active low
//             bus  - slave modport: phy_in_* / phy_out_*, scan_go_in/out,
//                    scan_rdy_in/out, bcm_rdy_in, reinit, busy
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hub75_init_inject_multi #(
  parameter int                    N_BANKS    = 2,
  parameter int                    N_CHANS    = 3,
  parameter int                    N_COLS     = 64,
  parameter int                    N_ROWS     = 32,
  parameter int                    N_REGS     = 2,
  parameter logic [N_REGS*16-1:0]  REG_VALS   = {16'h0040, 16'h7FFF},
  parameter logic [N_REGS*8-1:0]   REG_LE     = {8'd13, 8'd12},
  parameter int                    GAP_CYCLES = 4
) (
  input wire clk,
  input wire rst,
  hub75_init_inject_multi_if.slave bus
);

  localparam int c_LOG_N_ROWS = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int c_LANES      = N_BANKS * N_CHANS;
  // Bit index k and the LE threshold (up to N_COLS) share this width.
  localparam int c_BIT_W      = $clog2(N_COLS + 1);
  localparam int c_GAP_W      = $clog2(GAP_CYCLES + 1);
  // One counter serves both SHIFT (2*N_COLS half-bit steps) and GAP.
  localparam int c_CNT_W      = (c_BIT_W + 1 > c_GAP_W) ? c_BIT_W + 1 : c_GAP_W;
  localparam int c_IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1;

  localparam logic [c_CNT_W-1:0] c_SHIFT_LAST = c_CNT_W'(2 * N_COLS - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LAST   = c_CNT_W'(GAP_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(N_REGS - 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_PASS  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic                    r_pending;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_IDX_W-1:0]      r_idx;

  logic                    r_addr_inc;
  logic                    r_addr_rst;
  logic [c_LOG_N_ROWS-1:0] r_addr;
  logic [c_LANES-1:0]      r_data;
  logic                    r_clk;
  logic                    r_le;
  logic                    r_blank;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  state_t                  w_state_nxt;
  logic                    w_pending_nxt;
  logic [c_CNT_W-1:0]      w_cnt_nxt;
  logic [c_IDX_W-1:0]      w_idx_nxt;

  logic                    w_o_addr_inc;
  logic                    w_o_addr_rst;
  logic [c_LOG_N_ROWS-1:0] w_o_addr;
  logic [c_LANES-1:0]      w_o_data;
  logic                    w_o_clk;
  logic                    w_o_le;
  logic                    w_o_blank;

  logic                    w_pend;
  logic [15:0]             w_val;
  logic [c_BIT_W-1:0]      w_le_start;
  logic [c_BIT_W-1:0]      w_k;
  logic                    w_bit;
  logic                    w_le;

  // A request arriving this cycle counts as pending straight away, so the
  // ready towards upstream drops in the same cycle as reinit.
  assign w_pend = r_pending | bus.reinit;

  // Table lookup for the current entry: register word and first LE bit.
  always_comb begin
    w_val      = '0;
    w_le_start = '0;
    for (int e = 0; e < N_REGS; e++) begin
      if (r_idx == c_IDX_W'(e)) begin
        w_val      = REG_VALS[e*16 +: 16];
        w_le_start = c_BIT_W'(N_COLS - int'(REG_LE[e*8 +: 8]));
      end
    end
  end

  // r_cnt counts half-bit steps in SHIFT: bit k = r_cnt >> 1, r_cnt[0] is
  // the shift clock level. The 16-bit word repeats MSB-first along the chain.
  assign w_k   = r_cnt[c_BIT_W:1];
  assign w_bit = w_val[4'd15 - w_k[3:0]];
  assign w_le  = (w_k >= w_le_start);

  // Next state, counters and next PHY output values. The PHY outputs are
  // always taken from these through a register, so the injected bus and the
  // pass-through bus share one timing and mode changes cannot glitch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = w_pend;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;

    w_o_addr_inc  = 1'b0;
    w_o_addr_rst  = 1'b0;
    w_o_addr      = '0;
    w_o_data      = '0;
    w_o_clk       = 1'b0;
    w_o_le        = 1'b0;
    w_o_blank     = 1'b1;

    case (r_state)
      S_WAIT: begin
        if (bus.scan_rdy_in && bus.bcm_rdy_in) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end
      end

      S_SHIFT: begin
        w_o_clk  = r_cnt[0];
        w_o_data = {c_LANES{w_bit}};
        w_o_le   = w_le;
        if (r_cnt == c_SHIFT_LAST) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt   = S_PASS;
            // Only a request landing on this very cycle survives the clear;
            // earlier ones during the sequence are served by this replay.
            w_pending_nxt = bus.reinit;
          end else begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_SHIFT;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_PASS: begin
        w_o_addr_inc = bus.phy_in_addr_inc;
        w_o_addr_rst = bus.phy_in_addr_rst;
        w_o_addr     = bus.phy_in_addr;
        w_o_data     = bus.phy_in_data;
        w_o_clk      = bus.phy_in_clk;
        w_o_le       = bus.phy_in_le;
        w_o_blank    = bus.phy_in_blank;
        // Never cut a go already issued to scan; wait until it drops.
        if (w_pend && !bus.scan_go_in) begin
          w_state_nxt = S_WAIT;
        end
      end

      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_WAIT;
      r_pending  <= 1'b1;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_addr_inc <= 1'b0;
      r_addr_rst <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_clk      <= 1'b0;
      r_le       <= 1'b0;
      r_blank    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_pending  <= w_pending_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_addr_inc <= w_o_addr_inc;
      r_addr_rst <= w_o_addr_rst;
      r_addr     <= w_o_addr;
      r_data     <= w_o_data;
      r_clk      <= w_o_clk;
      r_le       <= w_o_le;
      r_blank    <= w_o_blank;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.phy_out_addr_inc = r_addr_inc;
  assign bus.phy_out_addr_rst = r_addr_rst;
  assign bus.phy_out_addr     = r_addr;
  assign bus.phy_out_data     = r_data;
  assign bus.phy_out_clk      = r_clk;
  assign bus.phy_out_le       = r_le;
  assign bus.phy_out_blank    = r_blank;

  assign bus.scan_go_out  = (r_state == S_PASS) & bus.scan_go_in;
  assign bus.scan_rdy_out = (r_state == S_PASS) & ~w_pend & bus.scan_rdy_in;
  assign bus.busy         = (r_state != S_PASS) | w_pend;

endmodule

`default_nettype wire

// File: tb/tb_hub75_init_inject_multi.sv
// ============================================================================
//  Module   : tb_hub75_init_inject_multi
//  Purpose  : Self-checking bench for hub75_init_inject_multi. A behavioural
//             model derives every expected output from the sequence step
//             number and the register table; directed phases pin the model
//             with hand-computed counts, then a randomized phase runs long.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hub75_init_inject_multi;

  localparam int M_COLS    = 64;
  localparam int M_GAP     = 4;
  localparam int M_REGS    = 2;
  localparam int ENTRY_LEN = 2 * M_COLS + M_GAP;
  localparam int SEQ_LEN   = M_REGS * ENTRY_LEN;
  localparam logic [15:0] RESET_VEC = 16'h0001;

  localparam int M_WAIT = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;

  logic clk;
  logic rst;

  logic       in_addr_inc, in_addr_rst, in_clk, in_le, in_blank;
  logic [4:0] in_addr;
  logic [5:0] in_data;
  logic       go_in, rdy_in, bcm_in, reinit;

  int n_vec;
  int n_err;
  bit chk_en;

  hub75_init_inject_multi_if #(.N_BANKS(2), .N_CHANS(3), .N_ROWS(32)) bus1();
  hub75_init_inject_multi_if #(.N_BANKS(1), .N_CHANS(3), .N_ROWS(32)) bus2();

  assign bus1.phy_in_addr_inc = in_addr_inc;
  assign bus1.phy_in_addr_rst = in_addr_rst;
  assign bus1.phy_in_addr     = in_addr;
  assign bus1.phy_in_data     = in_data;
  assign bus1.phy_in_clk      = in_clk;
  assign bus1.phy_in_le       = in_le;
  assign bus1.phy_in_blank    = in_blank;
  assign bus1.scan_go_in      = go_in;
  assign bus1.scan_rdy_in     = rdy_in;
  assign bus1.bcm_rdy_in      = bcm_in;
  assign bus1.reinit          = reinit;

  assign bus2.phy_in_addr_inc = in_addr_inc;
  assign bus2.phy_in_addr_rst = in_addr_rst;
  assign bus2.phy_in_addr     = in_addr;
  assign bus2.phy_in_data     = in_data[2:0];
  assign bus2.phy_in_clk      = in_clk;
  assign bus2.phy_in_le       = in_le;
  assign bus2.phy_in_blank    = in_blank;
  assign bus2.scan_go_in      = go_in;
  assign bus2.scan_rdy_in     = rdy_in;
  assign bus2.bcm_rdy_in      = bcm_in;
  assign bus2.reinit          = reinit;

  hub75_init_inject_multi dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  hub75_init_inject_multi #(
    .N_BANKS    (1),
    .N_CHANS    (3),
    .N_COLS     (32),
    .N_ROWS     (32),
    .N_REGS     (1),
    .REG_VALS   (16'hA5C3),
    .REG_LE     (8'd1),
    .GAP_CYCLES (4)
  ) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model (default-parameter instance)
  // --------------------------------------------------------------------------
  logic [15:0] m_vals [M_REGS];
  int          m_le   [M_REGS];
  int          m_mode;
  int          m_step;
  logic        m_pending;
  logic [15:0] exp_phy;

  initial begin
    m_vals[0] = 16'h7FFF;  m_le[0] = 12;
    m_vals[1] = 16'h0040;  m_le[1] = 13;
  end

  // Registered bus value the injector must show for sequence step s,
  // packed as {addr_inc, addr_rst, addr[4:0], data[5:0], clk, le, blank}.
  function automatic logic [15:0] step_vec(input int s);
    int   e, off, k;
    logic d, c, l;
    e   = s / ENTRY_LEN;
    off = s % ENTRY_LEN;
    d = 1'b0; c = 1'b0; l = 1'b0;
    if (off < 2 * M_COLS) begin
      k = off / 2;
      c = (off % 2) == 1;
      d = m_vals[e][15 - (k % 16)];
      l = (k >= M_COLS - m_le[e]);
    end
    return {1'b0, 1'b0, 5'd0, {6{d}}, c, l, 1'b1};
  endfunction

  initial begin
    logic pend;
    m_mode    = M_WAIT;
    m_step    = 0;
    m_pending = 1'b1;
    exp_phy   = RESET_VEC;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_mode    = M_WAIT;
        m_step    = 0;
        m_pending = 1'b1;
        exp_phy   = RESET_VEC;
      end else begin
        pend = m_pending | reinit;
        case (m_mode)
          M_WAIT: begin
            exp_phy   = RESET_VEC;
            m_pending = pend;
            if (rdy_in && bcm_in) begin
              m_mode = M_RUN;
              m_step = 0;
            end
          end
          M_RUN: begin
            exp_phy = step_vec(m_step);
            if (m_step == SEQ_LEN - 1) begin
              m_mode    = M_PASS;
              m_pending = reinit;
            end else begin
              m_step    = m_step + 1;
              m_pending = pend;
            end
          end
          default: begin
            exp_phy   = {in_addr_inc, in_addr_rst, in_addr, in_data, in_clk, in_le, in_blank};
            m_pending = pend;
            if (pend && !go_in) m_mode = M_WAIT;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Checking
  // --------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  logic [15:0] act_phy1;
  assign act_phy1 = {bus1.phy_out_addr_inc, bus1.phy_out_addr_rst, bus1.phy_out_addr,
                     bus1.phy_out_data, bus1.phy_out_clk, bus1.phy_out_le, bus1.phy_out_blank};

  initial begin
    logic [2:0] hs_exp;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("phy_out", {16'd0, act_phy1}, {16'd0, exp_phy});
        hs_exp[2] = (m_mode == M_PASS) && go_in;
        hs_exp[1] = (m_mode == M_PASS) && !(m_pending || reinit) && rdy_in;
        hs_exp[0] = (m_mode != M_PASS) || m_pending || reinit;
        check("go_rdy_busy", {29'd0, bus1.scan_go_out, bus1.scan_rdy_out, bus1.busy},
              {29'd0, hs_exp});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_addr_inc = 1'b0; in_addr_rst = 1'b0; in_addr = '0; in_data = '0;
    in_clk = 1'b0; in_le = 1'b0; in_blank = 1'b1;
  endtask

  // Runs until the default instance drops busy (bounded); counts visible
  // rising shift clocks, LE-high cycles, all-ones data cycles, and the same
  // for the small instance.
  task automatic measure(output int cyc, output int edges, output int les, output int ones,
                         output int d2b, output int d2e, output int d2l);
    logic p1, p2;
    cyc = 0; edges = 0; les = 0; ones = 0; d2b = 0; d2e = 0; d2l = 0;
    p1 = bus1.phy_out_clk;
    p2 = bus2.phy_out_clk;
    while (bus1.busy === 1'b1 && cyc < 2000) begin
      step();
      cyc++;
      if (bus1.phy_out_clk && !p1) edges++;
      p1 = bus1.phy_out_clk;
      if (bus1.phy_out_le) les++;
      if (bus1.phy_out_data == 6'h3F) ones++;
      if (bus2.busy) d2b++;
      if (bus2.phy_out_clk && !p2) d2e++;
      p2 = bus2.phy_out_clk;
      if (bus2.phy_out_le) d2l++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    int cyc, edges, les, ones, d2b, d2e, d2l, hi;
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    idle_inputs();
    go_in = 1'b0; rdy_in = 1'b1; bcm_in = 1'b1; reinit = 1'b0;
    rst = 1'b0;

    // Reset and default power-up sequence
    step();
    chk_en = 1'b1;
    step(); step();
    check("reset_phy", {16'd0, act_phy1}, {16'd0, RESET_VEC});
    check("reset_busy", {31'd0, bus1.busy}, 32'd1);
    check("reset_rdy_out", {31'd0, bus1.scan_rdy_out}, 32'd0);
    rst = 1'b1;
    measure(cyc, edges, les, ones, d2b, d2e, d2l);
    check("init_cycles", cyc, 265);
    check("init_clk_edges", edges, 128);
    check("init_le_cycles", les, 50);
    check("init_ones_cycles", ones, 128);
    check("small_busy_cycles", d2b, 68);
    check("small_clk_edges", d2e, 32);
    check("small_le_cycles", d2l, 2);

    // BCM not idle after reset: no shifting until it is
    rst = 1'b0; bcm_in = 1'b0;
    step(); step();
    rst = 1'b1;
    hi = 0;
    repeat (50) begin
      step();
      if (bus1.phy_out_clk || !bus1.phy_out_blank) hi++;
    end
    check("bcm_hold_quiet", hi, 0);
    bcm_in = 1'b1;
    measure(cyc, edges, les, ones, d2b, d2e, d2l);
    check("bcm_release_cycles", cyc, 265);
    check("bcm_release_edges", edges, 128);

    // Pass-through
    in_data = 6'h2A; in_le = 1'b1; in_blank = 1'b0; go_in = 1'b1;
    #1;
    check("pass_go_comb", {31'd0, bus1.scan_go_out}, 32'd1);
    step();
    check("pass_data", {26'd0, bus1.phy_out_data}, 32'h2A);
    check("pass_le_blank", {30'd0, bus1.phy_out_le, bus1.phy_out_blank}, 32'b10);

    // Re-init while a go is outstanding
    reinit = 1'b1;
    idle_inputs();
    #1;
    check("reinit_rdy_drop", {31'd0, bus1.scan_rdy_out}, 32'd0);
    check("reinit_busy", {31'd0, bus1.busy}, 32'd1);
    step();
    reinit = 1'b0;
    repeat (10) step();
    check("reinit_held_by_go", {31'd0, bus1.busy}, 32'd1);
    go_in = 1'b0;
    measure(cyc, edges, les, ones, d2b, d2e, d2l);
    check("reinit_cycles", cyc, 266);
    check("reinit_edges", edges, 128);
    repeat (300) step();
    check("reinit_single_replay", {31'd0, bus1.busy}, 32'd0);

    // Reset in the middle of the sequence
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (100) step();
    rst = 1'b0;
    step();
    check("midseq_reset_phy", {16'd0, act_phy1}, {16'd0, RESET_VEC});
    check("midseq_reset_busy", {31'd0, bus1.busy}, 32'd1);
    rst = 1'b1;
    measure(cyc, edges, les, ones, d2b, d2e, d2l);
    check("midseq_restart_cycles", cyc, 265);
    check("midseq_restart_edges", edges, 128);

    // Re-init on the very cycle the sequence completes
    rst = 1'b0;
    step();
    rst = 1'b1;
    repeat (264) step();
    reinit = 1'b1;
    step();
    reinit = 1'b0;
    check("edge_reinit_kept", {31'd0, bus1.busy}, 32'd1);
    measure(cyc, edges, les, ones, d2b, d2e, d2l);
    check("edge_reinit_cycles", cyc, 266);
    check("edge_reinit_edges", edges, 128);
    repeat (20) step();
    check("edge_reinit_done", {31'd0, bus1.busy}, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_addr_inc = 1'($urandom);
      in_addr_rst = 1'($urandom);
      in_addr     = 5'($urandom);
      in_data     = 6'($urandom);
      in_clk      = 1'($urandom);
      in_le       = 1'($urandom);
      in_blank    = 1'($urandom);
      go_in       = ($urandom_range(0, 3) == 0);
      rdy_in      = ($urandom_range(0, 3) != 0);
      bcm_in      = ($urandom_range(0, 3) != 0);
      reinit      = ($urandom_range(0, 59) == 0);
      rst         = ($urandom_range(0, 799) != 0);
      step();
    end
    rst = 1'b1; reinit = 1'b0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
